// File: rtl/fft_output_reorder_if.sv
// Purpose : bundles the sample-in and sample-out handshake buses of the FFT output reorder buffer.
// Latency : none, this is wiring only.
// Backpressure: in_ready throttles the FFT core and out_ready throttles this block's output stream.
// Ports   : in_valid/in_ready/in_re/in_im (bit-reversed samples in),
//           out_valid/out_ready/out_re/out_im/out_last (natural-order samples out), frame_done (drain pulse).
interface fft_output_reorder_if #(
   parameter int DW = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_re;
   logic [DW-1:0] in_im;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_re;
   logic [DW-1:0] out_im;
   logic          out_last;
   logic          frame_done;

   // master drives samples in and consumes samples out (FFT core plus downstream sink)
   modport master (
      output in_valid, in_re, in_im, out_ready,
      input  in_ready, out_valid, out_re, out_im, out_last, frame_done
   );

   // slave is the reorder buffer itself
   modport slave (
      input  in_valid, in_re, in_im, out_ready,
      output in_ready, out_valid, out_re, out_im, out_last, frame_done
   );
endinterface

// File: rtl/fft_output_reorder.sv
// Purpose : buffers one FFT frame written in bit-reversed order and replays it in natural order (ping-pong banks).
// Latency : bin 0 is presented the cycle after the last input of a frame is accepted; 1 sample/cycle sustained.
// Backpressure: in_ready drops only while both banks hold undrained frames; outputs hold while out_ready is low.
// Ports   : clk, rst_n (async active-low) plus bus (fft_output_reorder_if.slave) carrying both handshakes,
//           the natural-order output data, out_last and the frame_done pulse.
module fft_output_reorder #(
   parameter int N     = 16,
   parameter int LOG2N = 4,
   parameter int DW    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fft_output_reorder_if.slave  bus
);

   localparam logic [LOG2N-1:0] CNT_MAX = LOG2N'(N - 1);
   localparam logic [LOG2N-1:0] CNT_ONE = LOG2N'(1);

   logic [1:0]       full_q, full_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
   logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
   logic             frame_done_q, frame_done_d;

   // Two banks of N {re,im} words; contents are never reset, only full_q gates their use.
   logic [2*DW-1:0]  mem_q [2][N];
   logic [2*DW-1:0]  rd_word;

   logic             accept;
   logic             fire;
   logic             out_valid;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int i = 0; i < LOG2N; i++) begin
         r[i] = a[LOG2N-1-i];
      end
      return r;
   endfunction

   // in_ready sees only registered state, so a bank freed this cycle is offered next cycle.
   assign bus.in_ready = rst_n && !full_q[wr_bank_q];
   assign accept       = bus.in_valid && bus.in_ready;

   assign out_valid     = full_q[rd_bank_q];
   assign fire          = out_valid && bus.out_ready;
   assign rd_word       = mem_q[rd_bank_q][rd_cnt_q];
   assign bus.out_valid = out_valid;
   assign bus.out_re    = out_valid ? rd_word[2*DW-1:DW] : '0;
   assign bus.out_im    = out_valid ? rd_word[DW-1:0]    : '0;
   assign bus.out_last  = out_valid && (rd_cnt_q == CNT_MAX);
   assign bus.frame_done = frame_done_q;

   always_comb begin
      full_d       = full_q;
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      wr_cnt_d     = wr_cnt_q;
      rd_cnt_d     = rd_cnt_q;
      frame_done_d = 1'b0;

      if (accept) begin
         wr_cnt_d = wr_cnt_q + CNT_ONE;
         if (wr_cnt_q == CNT_MAX) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end
      end

      // A write-side fill and a read-side free in the same cycle always hit different banks,
      // so both updates to full_d can simply be applied.
      if (fire) begin
         rd_cnt_d = rd_cnt_q + CNT_ONE;
         if (rd_cnt_q == CNT_MAX) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            frame_done_d      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q       <= '0;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b0;
         wr_cnt_q     <= '0;
         rd_cnt_q     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         full_q       <= full_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         wr_cnt_q     <= wr_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Scatter writes: sample k of the frame lands at its natural-order address bitrev(k).
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_q[wr_bank_q][bitrev(wr_cnt_q)] <= {bus.in_re, bus.in_im};
      end
   end

endmodule

// File: tb/tb_fft_output_reorder.sv
`timescale 1ns/1ps
module tb_fft_output_reorder;
   localparam int N     = 16;
   localparam int LOG2N = 4;
   localparam int DW    = 16;
   localparam int BIG   = 1 << 30;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_output_reorder_if #(.DW(DW)) bus ();

   fft_output_reorder #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // stimulus controls, written by the main sequence
   int in_mode = 0, out_mode = 0, in_target = 0, out_target = 0;
   bit rnd_dat = 1'b0;

   // model / monitor state
   int in_done = 0, out_done = 0, rd_idx = 0, rdy_low = 0;
   int done_acc_cyc = -1, vld_rise_cyc = -1;
   bit fd_exp = 1'b0, prev_vld = 1'b0, hold_v = 1'b0;
   bit ev, er, inf, outf;
   logic [DW-1:0] hold_re, hold_im;
   logic hold_last;
   logic [2*DW-1:0] e;
   logic [2*DW-1:0] cur_in[$];
   logic [2*DW-1:0] exp_q[$];
   logic [2*DW-1:0] cap_q[$];

   // driver state
   int kk = 0, drv_frm = 0, seen = 0;
   bit have = 1'b0, adv = 1'b0;

   function automatic int brev(input int a);
      int r = 0;
      for (int i = 0; i < LOG2N; i++)
         if ((a & (1 << i)) != 0) r |= 1 << (LOG2N - 1 - i);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: frames are plain lists; a completed frame is permuted into natural order
   // and appended to the expected output stream. At most two undrained frames fit.
   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_out_last", bus.out_last, 0);
            chk("rst_frame_done", bus.frame_done, 0);
            chk("rst_out_re", bus.out_re, 0);
            chk("rst_out_im", bus.out_im, 0);
            cur_in.delete();
            exp_q.delete();
            rd_idx = 0; fd_exp = 1'b0; hold_v = 1'b0; prev_vld = 1'b0;
         end else begin
            ev = exp_q.size() > 0;
            er = (exp_q.size() + rd_idx) < 2 * N;
            chk("out_valid", bus.out_valid, ev);
            chk("in_ready", bus.in_ready, er);
            chk("frame_done", bus.frame_done, fd_exp);
            if (ev) begin
               e = exp_q[0];
               chk("out_re", bus.out_re, e[2*DW-1:DW]);
               chk("out_im", bus.out_im, e[DW-1:0]);
               chk("out_last", bus.out_last, rd_idx == N - 1);
            end else begin
               chk("idle_out_re", bus.out_re, 0);
               chk("idle_out_im", bus.out_im, 0);
               chk("idle_out_last", bus.out_last, 0);
            end
            if (hold_v) begin
               chk("stall_valid", bus.out_valid, 1);
               chk("stall_re", bus.out_re, hold_re);
               chk("stall_im", bus.out_im, hold_im);
               chk("stall_last", bus.out_last, hold_last);
            end
            hold_v = bus.out_valid && !bus.out_ready;
            hold_re = bus.out_re; hold_im = bus.out_im; hold_last = bus.out_last;
            if (bus.out_valid && !prev_vld) vld_rise_cyc = cyc;
            prev_vld = bus.out_valid;
            if (!bus.in_ready) rdy_low++;

            inf  = bus.in_valid && er;
            outf = ev && bus.out_ready;
            fd_exp = 1'b0;
            if (outf) begin
               cap_q.push_back({bus.out_re, bus.out_im});
               void'(exp_q.pop_front());
               out_done++;
               if (rd_idx == N - 1) begin
                  rd_idx = 0;
                  fd_exp = 1'b1;
               end else begin
                  rd_idx++;
               end
            end
            if (inf) begin
               cur_in.push_back({bus.in_re, bus.in_im});
               in_done++;
               if (cur_in.size() == N) begin
                  for (int i = 0; i < N; i++) exp_q.push_back(cur_in[brev(i)]);
                  cur_in.delete();
                  done_acc_cyc = cyc;
               end
            end
         end
      end
   end

   // Source and sink: the source holds valid and data until accepted.
   initial begin : driver
      bus.in_valid = 1'b0; bus.in_re = '0; bus.in_im = '0; bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            kk = 0; have = 1'b0; bus.in_valid = 1'b0; seen = in_done;
            bus.out_ready = 1'b0;
         end else begin
            adv = 1'b0;
            if (in_done != seen) begin
               seen = in_done; have = 1'b0; adv = 1'b1;
               if (kk == N - 1) begin kk = 0; drv_frm++; end
               else kk++;
            end
            if (!have) begin
               if (rnd_dat) begin
                  bus.in_re = DW'($urandom);
                  bus.in_im = DW'($urandom);
               end else begin
                  bus.in_re = DW'((drv_frm << 8) | brev(kk));
                  bus.in_im = -bus.in_re;
               end
               have = 1'b1;
            end
            if (!(bus.in_valid && !adv))
               bus.in_valid = (in_done < in_target) &&
                              (in_mode == 1 || (in_mode == 2 && $urandom_range(0, 1) == 1));
            bus.out_ready = (out_done < out_target) &&
                            (out_mode == 1 || (out_mode == 2 && $urandom_range(0, 1) == 1));
         end
      end
   end

   task automatic wait_in(input int tgt, input int budget);
      int n = 0;
      while (in_done < tgt && n < budget) begin @(posedge clk); n++; end
      chk("wait_in_accepts", in_done, tgt);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() > 0 || cur_in.size() > 0) && n < budget) begin @(posedge clk); n++; end
      chk("drain_left", exp_q.size() + cur_in.size(), 0);
      repeat (3) @(posedge clk);
   endtask

   // Natural-order frame with re = base|i, im = -(base|i), taken from what the DUT emitted.
   task automatic chk_frames(input string nm, input int base_c, input int f0, input int nfr);
      logic [DW-1:0] v, vn, cr, ci;
      logic [2*DW-1:0] c;
      chk({nm, "_count"}, cap_q.size() >= base_c + nfr * N, 1);
      if (cap_q.size() >= base_c + nfr * N) begin
         for (int f = 0; f < nfr; f++)
            for (int i = 0; i < N; i++) begin
               c = cap_q[base_c + f * N + i];
               cr = c[2*DW-1:DW]; ci = c[DW-1:0];
               v = DW'(((f0 + f) << 8) | i); vn = -v;
               chk({nm, "_re"}, cr, v);
               chk({nm, "_im"}, ci, vn);
            end
      end
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int base_c, f0, r0, got;
      bit prev_rdy;
      logic [DW-1:0] b0, b0n;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // single frame, sink always ready
      out_mode = 1; out_target = BIG; in_mode = 1; rnd_dat = 1'b0;
      base_c = cap_q.size(); f0 = drv_frm;
      in_target = in_done + N;
      wait_in(in_target, 200);
      wait_drain(200);
      chk_frames("single", base_c, f0, 1);
      chk("latency_first_valid", vld_rise_cyc, done_acc_cyc + 1);

      // three frames back to back
      r0 = rdy_low; base_c = cap_q.size(); f0 = drv_frm;
      in_target = in_done + 3 * N;
      wait_in(in_target, 300);
      wait_drain(300);
      chk_frames("pingpong", base_c, f0, 3);
      chk("pingpong_in_ready_drops", rdy_low - r0, 0);

      // backpressure: two frames fill both banks
      out_mode = 0; f0 = drv_frm;
      in_target = in_done + 2 * N;
      wait_in(in_target, 300);
      @(negedge clk); #1;
      b0 = DW'(f0 << 8); b0n = -b0;
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_bin0_re", bus.out_re, b0);
      chk("bp_bin0_im", bus.out_im, b0n);
      out_mode = 1;
      got = 0; prev_rdy = bus.in_ready;
      for (int n = 0; n < 100 && got == 0; n++) begin
         @(negedge clk); #1;
         if (bus.frame_done) begin
            got = 1;
            chk("bp_rdy_after_last", bus.in_ready, 1);
            chk("bp_rdy_during_last", prev_rdy, 0);
         end
         prev_rdy = bus.in_ready;
      end
      chk("bp_frame_done_seen", got, 1);
      wait_drain(300);

      // random valid/ready with random data
      rnd_dat = 1'b1; in_mode = 2; out_mode = 2;
      in_target = in_done + 20 * N;
      wait_in(in_target, 8000);
      wait_drain(4000);

      // reset mid-operation: frame 0 at rd_cnt 5, frame 1 holds 7 samples
      rnd_dat = 1'b0; in_mode = 1; out_mode = 0;
      in_target = in_done + N;
      wait_in(in_target, 200);
      in_target = in_done + 7;
      wait_in(in_target, 200);
      out_target = out_done + 5; out_mode = 1;
      for (int n = 0; n < 100 && out_done < out_target; n++) @(posedge clk);
      chk("rst_pre_reads", out_done, out_target);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("rst_now_out_valid", bus.out_valid, 0);
      chk("rst_now_in_ready", bus.in_ready, 0);
      repeat (2) @(posedge clk);
      out_target = BIG;
      #3 rst_n = 1'b1;
      @(negedge clk); #1;
      chk("post_rst_no_valid", bus.out_valid, 0);
      base_c = cap_q.size(); f0 = drv_frm;
      in_target = in_done + N;
      wait_in(in_target, 200);
      wait_drain(200);
      chk_frames("post_rst", base_c, f0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
